// File: rtl/lemv8_pkg.sv
// Shared LEGv8 encodings: ALU operation codes, R-type opcodes, immediate
// formats and main-control ALUOp values.
package lemv8_pkg;

   localparam int ZERO_REG = 31;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;

   typedef enum logic [1:0] {
      IMM_I    = 2'b00,
      IMM_D    = 2'b01,
      IMM_CB   = 2'b10,
      IMM_NONE = 2'b11
   } imm_type_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_PASSB = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_RSVD  = 2'b11
   } alu_op_e;

endpackage

// File: rtl/id_ex_operand_stage_alu_control.sv
// Maps main-control ALUOp plus the R-type opcode field to a 4-bit ALU
// operation; unknown R-type opcodes fall back to ADD and raise illegal.
module alu_control
   import lemv8_pkg::*;
(
   input  logic [1:0]  alu_op,
   input  logic [10:0] opcode,
   output logic [3:0]  operation,
   output logic        illegal
);

   always_comb begin
      operation = ALU_ADD;
      illegal   = 1'b0;
      case (alu_op)
         ALUOP_ADD:   operation = ALU_ADD;
         ALUOP_PASSB: operation = ALU_PASSB;
         ALUOP_RTYPE: begin
            case (opcode)
               OPC_ADD: operation = ALU_ADD;
               OPC_SUB: operation = ALU_SUB;
               OPC_AND: operation = ALU_AND;
               OPC_ORR: operation = ALU_OR;
               default: illegal   = 1'b1;
            endcase
         end
         default:     operation = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side immediate build, ALU control decode,
// operand forwarding and load-use bubble insertion in front of the ALU.
module id_ex_operand_stage #(
   parameter int DATA_W    = 64,
   parameter int REG_IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          instr,
   input  logic [1:0]           alu_op,
   input  logic                 alu_src,
   input  logic [1:0]           imm_type,
   input  logic [REG_IDX_W-1:0] rn_idx,
   input  logic [REG_IDX_W-1:0] rm_idx,
   input  logic [DATA_W-1:0]    rn_data,
   input  logic [DATA_W-1:0]    rm_data,
   input  logic                 flush,
   input  logic                 ex_mem_regwrite,
   input  logic                 ex_mem_memread,
   input  logic [REG_IDX_W-1:0] ex_mem_rd,
   input  logic [DATA_W-1:0]    ex_mem_result,
   input  logic                 mem_wb_regwrite,
   input  logic [REG_IDX_W-1:0] mem_wb_rd,
   input  logic [DATA_W-1:0]    mem_wb_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    input1,
   output logic [DATA_W-1:0]    input2,
   output logic [3:0]           operation,
   output logic [DATA_W-1:0]    store_data,
   output logic                 illegal_op
);
   import lemv8_pkg::*;

   localparam logic [REG_IDX_W-1:0] XZR = REG_IDX_W'(ZERO_REG);

   logic                 valid_q;
   logic [31:0]          instr_q;
   logic [1:0]           alu_op_q;
   logic                 alu_src_q;
   imm_type_e            imm_type_q;
   logic [REG_IDX_W-1:0] rn_q, rm_q;
   logic [DATA_W-1:0]    rn_data_q, rm_data_q;

   logic [DATA_W-1:0]    imm_ext, fwd_a, fwd_b;
   logic                 load_use, is_store, rtype_illegal;

   assign in_ready  = !valid_q || (out_valid && out_ready);
   assign out_valid = valid_q && !load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         alu_op_q   <= '0;
         alu_src_q  <= 1'b0;
         imm_type_q <= IMM_I;
         rn_q       <= '0;
         rm_q       <= '0;
         rn_data_q  <= '0;
         rm_data_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         valid_q    <= 1'b1;
         instr_q    <= instr;
         alu_op_q   <= alu_op;
         alu_src_q  <= alu_src;
         imm_type_q <= imm_type_e'(imm_type);
         rn_q       <= rn_idx;
         rm_q       <= rm_idx;
         rn_data_q  <= rn_data;
         rm_data_q  <= rm_data;
      end else if (out_valid && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_comb begin
      imm_ext = '0;
      case (imm_type_q)
         IMM_I:   imm_ext = DATA_W'(instr_q[21:10]);
         IMM_D:   imm_ext = {{(DATA_W-9){instr_q[20]}}, instr_q[20:12]};
         IMM_CB:  imm_ext = {{(DATA_W-19){instr_q[23]}}, instr_q[23:5]};
         default: imm_ext = '0;
      endcase
   end

   // A loaded value in EX/MEM is not yet available, so only MEM/WB may serve it.
   function automatic logic [DATA_W-1:0] fwd(
      input logic [REG_IDX_W-1:0] src,
      input logic [DATA_W-1:0]    rf,
      input logic                 em_rw,
      input logic                 em_mr,
      input logic [REG_IDX_W-1:0] em_rd,
      input logic [DATA_W-1:0]    em_res,
      input logic                 wb_rw,
      input logic [REG_IDX_W-1:0] wb_rd,
      input logic [DATA_W-1:0]    wb_res
   );
      if (src == XZR)                            return '0;
      else if (em_rw && em_rd == src && !em_mr)  return em_res;
      else if (wb_rw && wb_rd == src)            return wb_res;
      else                                       return rf;
   endfunction

   always_comb begin
      fwd_a = fwd(rn_q, rn_data_q, ex_mem_regwrite, ex_mem_memread, ex_mem_rd,
                  ex_mem_result, mem_wb_regwrite, mem_wb_rd, mem_wb_result);
      fwd_b = fwd(rm_q, rm_data_q, ex_mem_regwrite, ex_mem_memread, ex_mem_rd,
                  ex_mem_result, mem_wb_regwrite, mem_wb_rd, mem_wb_result);
   end

   // Rm matters to a load-use hazard when it feeds the ALU or is the STUR data.
   assign is_store = (instr_q[31:21] == OPC_STUR);

   always_comb begin
      load_use = 1'b0;
      if (ex_mem_memread && ex_mem_regwrite && ex_mem_rd != XZR) begin
         if (ex_mem_rd == rn_q)
            load_use = 1'b1;
         if (ex_mem_rd == rm_q && (!alu_src_q || is_store))
            load_use = 1'b1;
      end
   end

   alu_control u_alu_control (
      .alu_op    (alu_op_q),
      .opcode    (instr_q[31:21]),
      .operation (operation),
      .illegal   (rtype_illegal)
   );

   assign illegal_op = valid_q && rtype_illegal;
   assign input1     = fwd_a;
   assign input2     = alu_src_q ? imm_ext : fwd_b;
   assign store_data = fwd_b;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed vectors push expected
// ALU operands; a negedge monitor pops and compares on every handshake.
module tb_id_ex_operand_stage;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [31:0] instr;
   logic [1:0]  alu_op;
   logic        alu_src;
   logic [1:0]  imm_type;
   logic [4:0]  rn_idx, rm_idx;
   logic [63:0] rn_data, rm_data;
   logic        flush;
   logic        ex_mem_regwrite, ex_mem_memread;
   logic [4:0]  ex_mem_rd;
   logic [63:0] ex_mem_result;
   logic        mem_wb_regwrite;
   logic [4:0]  mem_wb_rd;
   logic [63:0] mem_wb_result;
   logic        out_valid, out_ready;
   logic [63:0] input1, input2, store_data;
   logic [3:0]  operation;
   logic        illegal_op;

   id_ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .alu_op(alu_op), .alu_src(alu_src), .imm_type(imm_type),
      .rn_idx(rn_idx), .rm_idx(rm_idx), .rn_data(rn_data), .rm_data(rm_data),
      .flush(flush), .ex_mem_regwrite(ex_mem_regwrite),
      .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
      .ex_mem_result(ex_mem_result), .mem_wb_regwrite(mem_wb_regwrite),
      .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
      .out_valid(out_valid), .out_ready(out_ready), .input1(input1),
      .input2(input2), .operation(operation), .store_data(store_data),
      .illegal_op(illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  aop;
      logic        asrc;
      logic [1:0]  it;
      logic [4:0]  rn, rm;
      logic [63:0] rnd, rmd;
      logic        em_rw, em_mr;
      logic [4:0]  em_rd;
      logic [63:0] em_res;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [63:0] wb_res;
      logic [63:0] e_in1, e_in2, e_sd;
      logic [3:0]  e_op;
      logic        e_ill;
   } vec_t;

   typedef struct {
      logic [63:0] in1, in2, sd;
      logic [3:0]  op;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [199:0] act, input logic [199:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic vec_t mkv(
      input logic [31:0] ins, input logic [1:0] aop, input logic asrc,
      input logic [1:0] it, input logic [4:0] rn, input logic [4:0] rm,
      input logic [63:0] rnd, input logic [63:0] rmd,
      input logic [63:0] e1, input logic [63:0] e2, input logic [3:0] eop,
      input logic [63:0] esd, input logic eill);
      vec_t v;
      v.instr = ins; v.aop = aop; v.asrc = asrc; v.it = it;
      v.rn = rn; v.rm = rm; v.rnd = rnd; v.rmd = rmd;
      v.em_rw = 0; v.em_mr = 0; v.em_rd = 0; v.em_res = 0;
      v.wb_rw = 0; v.wb_rd = 0; v.wb_res = 0;
      v.e_in1 = e1; v.e_in2 = e2; v.e_op = eop; v.e_sd = esd; v.e_ill = eill;
      return v;
   endfunction

   task automatic send(input vec_t v, input bit push);
      int n;
      exp_t e;
      @(posedge clk); #1;
      instr = v.instr; alu_op = v.aop; alu_src = v.asrc; imm_type = v.it;
      rn_idx = v.rn; rm_idx = v.rm; rn_data = v.rnd; rm_data = v.rmd;
      ex_mem_regwrite = v.em_rw; ex_mem_memread = v.em_mr;
      ex_mem_rd = v.em_rd; ex_mem_result = v.em_res;
      mem_wb_regwrite = v.wb_rw; mem_wb_rd = v.wb_rd; mem_wb_result = v.wb_res;
      if (push) begin
         e.in1 = v.e_in1; e.in2 = v.e_in2; e.sd = v.e_sd;
         e.op = v.e_op; e.ill = v.e_ill;
         exp_q.push_back(e);
      end
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready never rose");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: in1=%h in2=%h op=%b", input1, input2, operation);
         end else begin
            e = exp_q.pop_front();
            check("operands", {input1, input2, store_data, operation, illegal_op},
                  {e.in1, e.in2, e.sd, e.op, e.ill});
         end
      end
   end

   localparam logic [10:0] O_ADD = 11'b10001011000;
   localparam logic [10:0] O_SUB = 11'b11001011000;
   localparam logic [10:0] O_AND = 11'b10001010000;
   localparam logic [10:0] O_ORR = 11'b10101010000;
   localparam logic [10:0] O_BAD = 11'b11111111111;

   vec_t v;
   logic [199:0] snap;

   initial begin
      rst_n = 0; in_valid = 0; instr = 0; alu_op = 0; alu_src = 0; imm_type = 0;
      rn_idx = 0; rm_idx = 0; rn_data = 0; rm_data = 0; flush = 0;
      ex_mem_regwrite = 0; ex_mem_memread = 0; ex_mem_rd = 0; ex_mem_result = 0;
      mem_wb_regwrite = 0; mem_wb_rd = 0; mem_wb_result = 0; out_ready = 1;
      #12;
      check("reset_outputs", {out_valid, input1, input2, store_data, operation, illegal_op, in_ready},
            {1'b0, 64'd0, 64'd0, 64'd0, 4'b0010, 1'b0, 1'b1});
      @(negedge clk); rst_n = 1;

      // R-type ALU decode
      send(mkv({O_ADD, 21'h0}, 2'b10, 0, 2'b11, 2, 3, 5, 7, 5, 7, 4'b0010, 7, 0), 1);
      send(mkv({O_SUB, 21'h0}, 2'b10, 0, 2'b11, 2, 3, 9, 4, 9, 4, 4'b0110, 4, 0), 1);
      send(mkv({O_AND, 21'h0}, 2'b10, 0, 2'b11, 2, 3, 'hF0, 'h3C, 'hF0, 'h3C, 4'b0000, 'h3C, 0), 1);
      send(mkv({O_ORR, 21'h0}, 2'b10, 0, 2'b11, 2, 3, 'hF0, 'h3C, 'hF0, 'h3C, 4'b0001, 'h3C, 0), 1);
      // Immediates: LDUR -8, ADDI 0xFFF zero-extended, CB -1, none with ALUOp 11
      send(mkv({11'b11111000010, 9'h1F8, 2'b00, 5'd2, 5'd1}, 2'b00, 1, 2'b01, 2, 1, 100, 'h77,
               100, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0010, 'h77, 0), 1);
      send(mkv({10'b1001000100, 12'hFFF, 5'd2, 5'd1}, 2'b00, 1, 2'b00, 2, 0, 1, 0,
               1, 64'h0000_0000_0000_0FFF, 4'b0010, 0, 0), 1);
      send(mkv({8'b10110100, 19'h7FFFF, 5'd3}, 2'b01, 1, 2'b10, 0, 3, 'h11, 'h22,
               'h11, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0111, 'h22, 0), 1);
      send(mkv({8'b10110100, 19'h7FFFF, 5'd3}, 2'b01, 0, 2'b10, 0, 3, 'h11, 'h22,
               'h11, 'h22, 4'b0111, 'h22, 0), 1);
      send(mkv({O_ADD, 21'h1234}, 2'b11, 1, 2'b11, 2, 3, 6, 8, 6, 0, 4'b0010, 8, 0), 1);

      // Forwarding: EX/MEM beats MEM/WB, XZR reads 0, MEM/WB alone, B path
      v = mkv({O_ADD, 21'h0}, 2'b10, 0, 2'b11, 4, 3, 1, 7, 'hAA, 7, 4'b0010, 7, 0);
      v.em_rw = 1; v.em_rd = 4; v.em_res = 'hAA; v.wb_rw = 1; v.wb_rd = 4; v.wb_res = 'hBB;
      send(v, 1);
      v.rn = 31; v.e_in1 = 0;
      send(v, 1);
      v.rn = 4; v.em_rw = 0; v.e_in1 = 'hBB;
      send(v, 1);
      v = mkv({O_ADD, 21'h0}, 2'b10, 0, 2'b11, 2, 4, 1, 7, 1, 'hAA, 4'b0010, 'hAA, 0);
      v.em_rw = 1; v.em_rd = 4; v.em_res = 'hAA;
      send(v, 1);

      // Load-use on Rm = 9, resolved next cycle through MEM/WB
      v = mkv({O_ADD, 21'h0}, 2'b10, 0, 2'b11, 2, 9, 3, 1, 3, 'h55, 4'b0010, 'h55, 0);
      v.em_rw = 1; v.em_mr = 1; v.em_rd = 9; v.em_res = 'hEE;
      send(v, 1);
      @(negedge clk);
      check("loaduse_bubble", {out_valid, in_ready}, {1'b0, 1'b0});
      @(posedge clk); #1;
      ex_mem_regwrite = 0; ex_mem_memread = 0;
      mem_wb_regwrite = 1; mem_wb_rd = 9; mem_wb_result = 'h55;
      @(posedge clk); #1;

      // Stall for 3 cycles with a new instruction waiting, then flush
      out_ready = 0;
      send(mkv({O_ADD, 21'h0}, 2'b10, 0, 2'b11, 5, 6, 10, 20, 0, 0, 0, 0, 0), 0);
      in_valid = 1; instr = {O_SUB, 21'h0}; rn_data = 99;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_hold", {out_valid, in_ready, input1, input2, operation},
               {1'b1, 1'b0, 64'd10, 64'd20, 4'b0010});
      end
      @(posedge clk); #1; flush = 1;
      @(posedge clk); #1; flush = 0; in_valid = 0;
      @(negedge clk);
      check("flush_kill", {out_valid, in_ready}, {1'b0, 1'b1});
      out_ready = 1;

      // Unknown R-type opcode, then async reset while stalled on it
      send(mkv({O_BAD, 21'h0}, 2'b10, 0, 2'b11, 2, 3, 1, 2, 1, 2, 4'b0010, 2, 1), 1);
      @(posedge clk); #1; out_ready = 0;
      send(mkv({O_BAD, 21'h0}, 2'b10, 0, 2'b11, 2, 3, 1, 2, 0, 0, 0, 0, 0), 0);
      @(negedge clk);
      check("illegal_stalled", {out_valid, illegal_op, in_ready}, {1'b1, 1'b1, 1'b0});
      #2 rst_n = 0;
      #1;
      snap = {out_valid, input1, input2, store_data, operation, illegal_op, in_ready};
      check("reset_midstall", snap, {1'b0, 64'd0, 64'd0, 64'd0, 4'b0010, 1'b0, 1'b1});
      @(negedge clk); rst_n = 1; out_ready = 1;
      repeat (3) @(posedge clk);
      check("scoreboard_drained", 200'(exp_q.size()), 200'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
